// File: rtl/std_fifo_reader_pkg.sv
// Shared sizing helpers for the FIFO reader and its skid buffer.
package std_fifo_reader_pkg;

  localparam int LATENCY_MIN = 0;
  localparam int LATENCY_MAX = 4;

  // Bits needed to represent v, never less than 1, so a one-entry buffer still has an index bit.
  function automatic int log2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

  // One slot per in-flight pop plus one to keep streaming while the head word waits.
  function automatic int skid_depth(input int latency);
    return latency + 1;
  endfunction

  function automatic int skid_addr_width(input int depth);
    return log2(depth - 1);
  endfunction

endpackage

// File: rtl/std_fifo_reader_if.sv
// FIFO-side and stream-side signals of the reader, bundled for port connection.
interface std_fifo_reader_if #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = std_fifo_reader_pkg::skid_addr_width(
                            std_fifo_reader_pkg::skid_depth(LATENCY)) + 1
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_q;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_count;
  logic             busy;

  modport master (
    input  fifo_empty, fifo_q, out_ready,
    output fifo_pop, out_valid, out_data, out_count, busy
  );

  modport slave (
    output fifo_empty, fifo_q, out_ready,
    input  fifo_pop, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/std_fifo_reader_skid.sv
// Small register FIFO holding words that have landed but not yet been accepted downstream.
// Pointers carry a wrap bit and wrap explicitly at DEPTH-1, so DEPTH need not be a power of two.
module std_skid_buf
  import std_fifo_reader_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int AW    = skid_addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d, count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == LAST_IDX) return {~p[AW], {AW{1'b0}}};
    return p + 1'b1;
  endfunction

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
  assign q_o     = mem_q[rd_q[AW-1:0]];
  assign count_o = count_q;

  // Pointer and occupancy next-state; push and pop together leave the count unchanged.
  always_comb begin
    wr_d    = push_i ? ptr_inc(wr_q) : wr_q;
    rd_d    = pop_i ? ptr_inc(rd_q) : rd_q;
    count_d = count_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= d_i;
  end

  // Simulation-only guard: reading an empty buffer means the credit logic is broken.
  always_ff @(posedge clk) begin
    if (rst) assert (!(pop_i && empty_o));
  end

endmodule

// File: rtl/std_fifo_reader.sv
// Consumer-side companion to std_fifo: issues pops against a credit budget, absorbs the
// FIFO's pop-to-q latency, and re-presents the data as a registered valid/ready stream.
module std_fifo_reader
  import std_fifo_reader_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int LATENCY         = 1,
  parameter int SKID_DEPTH      = skid_depth(LATENCY),
  parameter int SKID_ADDR_WIDTH = skid_addr_width(SKID_DEPTH)
) (
  input logic               clk,
  input logic               rst,
  std_fifo_reader_if.master bus
);
  localparam int CW = SKID_ADDR_WIDTH + 2;

  logic                     pop, land, deq, credit_ok;
  logic                     skid_full, skid_empty;
  logic [SKID_ADDR_WIDTH:0] count;
  logic [CW-1:0]            n_inflight, credit_sum;

  if (LATENCY > 0) begin : g_inflight
    logic [LATENCY-1:0] inflight_q, inflight_d;

    // Shift in this cycle's pop; the oldest bit marks fifo_q being valid now.
    always_comb inflight_d = LATENCY'({inflight_q, pop});

    // In-flight tracker register with synchronous active-low reset.
    always_ff @(posedge clk) begin
      if (!rst) inflight_q <= '0;
      else      inflight_q <= inflight_d;
    end

    assign land       = inflight_q[LATENCY-1];
    assign n_inflight = CW'($countones(inflight_q));
  end else begin : g_no_inflight
    assign land       = pop;
    assign n_inflight = '0;
  end

  // deq implies count >= 1, so the subtraction cannot wrap.
  assign deq        = !skid_empty && bus.out_ready;
  assign credit_sum = CW'(count) + n_inflight - CW'(deq);
  assign credit_ok  = credit_sum < CW'(SKID_DEPTH);
  assign pop        = rst && !bus.fifo_empty && credit_ok;

  std_skid_buf #(
    .WIDTH (WIDTH),
    .DEPTH (SKID_DEPTH),
    .AW    (SKID_ADDR_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (land),
    .pop_i   (deq),
    .d_i     (bus.fifo_q),
    .q_o     (bus.out_data),
    .count_o (count),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = !skid_empty;
  assign bus.out_count = count;
  assign bus.busy      = (n_inflight != '0) || (count != '0);

  // Simulation-only guards: illegal latency, or a word landing with nowhere to go.
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (LATENCY >= LATENCY_MIN && LATENCY <= LATENCY_MAX);
      assert (!(land && skid_full && !deq));
    end
  end

endmodule

// File: tb/tb_std_fifo_reader.sv
// Directed and random checks of std_fifo_reader at LATENCY 0, 1 and 2 against a
// behavioural FIFO model and an in-order scoreboard.
module tb_std_fifo_reader;
  import std_fifo_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic out_ready;
  int   sel;
  bit   mon_en;
  int   total = 0;
  int   bad   = 0;

  std_fifo_reader_if #(.WIDTH(8), .LATENCY(0)) bus0 ();
  std_fifo_reader_if #(.WIDTH(8), .LATENCY(1)) bus1 ();
  std_fifo_reader_if #(.WIDTH(8), .LATENCY(2)) bus2 ();

  std_fifo_reader #(.WIDTH(8), .LATENCY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  std_fifo_reader #(.WIDTH(8), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  std_fifo_reader #(.WIDTH(8), .LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Behavioural source FIFO shared by whichever instance is selected.
  logic [7:0] src_mem [4096];
  int         src_wr = 0;
  int         src_rd = 0;
  logic [7:0] pipe [4];
  logic [7:0] exp_q [$];

  logic       pop_s, empty_s, valid_s, busy_s;
  logic [7:0] data_s;
  int         count_s, depth_s;

  assign bus0.fifo_empty = (sel != 0) || (src_wr == src_rd);
  assign bus1.fifo_empty = (sel != 1) || (src_wr == src_rd);
  assign bus2.fifo_empty = (sel != 2) || (src_wr == src_rd);
  assign bus0.fifo_q     = src_mem[src_rd[11:0]];
  assign bus1.fifo_q     = pipe[0];
  assign bus2.fifo_q     = pipe[1];
  assign bus0.out_ready  = out_ready;
  assign bus1.out_ready  = out_ready;
  assign bus2.out_ready  = out_ready;

  always_comb begin
    pop_s = bus1.fifo_pop; empty_s = bus1.fifo_empty; valid_s = bus1.out_valid;
    busy_s = bus1.busy; data_s = bus1.out_data; count_s = int'(bus1.out_count); depth_s = 2;
    if (sel == 0) begin
      pop_s = bus0.fifo_pop; empty_s = bus0.fifo_empty; valid_s = bus0.out_valid;
      busy_s = bus0.busy; data_s = bus0.out_data; count_s = int'(bus0.out_count); depth_s = 1;
    end else if (sel == 2) begin
      pop_s = bus2.fifo_pop; empty_s = bus2.fifo_empty; valid_s = bus2.out_valid;
      busy_s = bus2.busy; data_s = bus2.out_data; count_s = int'(bus2.out_count); depth_s = 3;
    end
  end

  // FIFO read pipeline: word popped in cycle k shows at pipe[L-1] in cycle k+L.
  always @(posedge clk) begin
    if (!rst) begin
      src_rd <= src_wr;
      for (int i = 0; i < 4; i++) pipe[i] <= 8'h00;
    end else begin
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      if (pop_s) begin
        pipe[0] <= src_mem[src_rd[11:0]];
        src_rd  <= src_rd + 1;
      end else begin
        pipe[0] <= 8'h00;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input logic [7:0] w);
    src_mem[src_wr[11:0]] = w;
    src_wr++;
    exp_q.push_back(w);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy_s) && n < 3000) begin
      cyc();
      n++;
    end
    chk({tag, "_timeout"}, int'(n < 3000), 1);
    chk({tag, "_leftover"}, exp_q.size(), 0);
  endtask

  task automatic rand_run(input int s);
    int pushed;
    pushed = 0;
    sel = s;
    while (pushed < 1000) begin
      cyc();
      out_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        push(8'($urandom_range(0, 255)));
        pushed++;
      end
    end
    drain("random");
  endtask

  // Scoreboard and invariants for the selected instance.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pop_when_empty", int'(pop_s && empty_s), 0);
      chk("count_le_depth", int'(count_s <= depth_s), 1);
      if (valid_s && out_ready) begin
        chk("sb_has_word", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_data", int'(data_s), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    int npops;
    rst = 1'b0; out_ready = 1'b0; sel = 1; mon_en = 1'b0;
    cyc(); cyc();
    smp();
    chk("rst_valid", int'(valid_s), 0);
    chk("rst_count", count_s, 0);
    chk("rst_busy", int'(busy_s), 0);
    chk("rst_pop", int'(pop_s), 0);
    chk("rst_valid_l0", int'(bus0.out_valid), 0);
    chk("rst_busy_l2", int'(bus2.busy), 0);
    cyc();
    rst = 1'b1; mon_en = 1'b1;

    // Stream, LATENCY=1: 16 words preloaded, consumer always ready.
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) push(8'(i + 1));
    for (int i = 0; i < 18; i++) begin
      smp();
      chk("stream_pop", int'(pop_s), int'(i < 16));
      chk("stream_valid", int'(valid_s), int'(i >= 2));
      chk("stream_busy", int'(busy_s), int'(i >= 1));
      if (i == 2) chk("stream_first", int'(data_s), 8'h01);
      cyc();
    end
    smp();
    chk("stream_busy_end", int'(busy_s), 0);
    chk("stream_drained", exp_q.size(), 0);

    // Stall, LATENCY=1: 10 cycles not ready, then continuous drain.
    cyc();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
    npops = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      npops += int'(pop_s);
      cyc();
    end
    smp();
    chk("stall_pops", npops, 2);
    chk("stall_count", count_s, 2);
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      smp();
      chk("stall_nogap", int'(valid_s), 1);
      cyc();
    end
    smp();
    chk("stall_valid_end", int'(valid_s), 0);
    chk("stall_drained", exp_q.size(), 0);

    // Trickle, LATENCY=1: single word into an empty FIFO.
    cyc();
    push(8'hA5);
    smp();
    chk("trk_pop0", int'(pop_s), 1);
    chk("trk_busy0", int'(busy_s), 0);
    cyc();
    smp();
    chk("trk_pop1", int'(pop_s), 0);
    chk("trk_busy1", int'(busy_s), 1);
    chk("trk_valid1", int'(valid_s), 0);
    cyc();
    smp();
    chk("trk_valid2", int'(valid_s), 1);
    chk("trk_data2", int'(data_s), 8'hA5);
    chk("trk_busy2", int'(busy_s), 1);
    cyc();
    smp();
    chk("trk_busy3", int'(busy_s), 0);
    chk("trk_valid3", int'(valid_s), 0);

    // Reset mid-stream, LATENCY=2: two words buffered, one still in flight.
    cyc();
    sel = 2;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'(8'h41 + i));
    for (int i = 0; i < 4; i++) cyc();
    rst = 1'b0;
    exp_q.delete();
    smp();
    chk("mrst_count_pre", count_s, 2);
    chk("mrst_pop_forced", int'(pop_s), 0);
    cyc();
    rst = 1'b1;
    smp();
    chk("mrst_valid", int'(valid_s), 0);
    chk("mrst_count", count_s, 0);
    chk("mrst_busy", int'(busy_s), 0);
    cyc();
    for (int i = 0; i < 4; i++) push(8'(8'h51 + i));
    drain("mrst");

    // Simultaneous land and deq with a full buffer, LATENCY=0.
    cyc();
    sel = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(8'(8'h61 + i));
    smp();
    chk("sim_pop0", int'(pop_s), 1);
    chk("sim_count0", count_s, 0);
    cyc();
    smp();
    chk("sim_pop1", int'(pop_s), 0);
    chk("sim_count1", count_s, 1);
    cyc();
    out_ready = 1'b1;
    smp();
    chk("sim_pop2", int'(pop_s), 1);
    chk("sim_count2", count_s, 1);
    chk("sim_data2", int'(data_s), 8'h61);
    cyc();
    smp();
    chk("sim_count3", count_s, 1);
    chk("sim_data3", int'(data_s), 8'h62);
    drain("sim");

    // Random back-pressure at LATENCY=2 and LATENCY=0.
    rand_run(2);
    rand_run(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
